// File: rtl/fft_twd_seq.sv
// Stage-0 FFT twiddle sequencer: tracks the beat position within each frame and
// drives the twiddle select. It also frames the stream with delayed SOP/EOP/valid.
module fft_twd_seq #(
  parameter int FRAME_CLKS = 32,
  parameter int IDX_SHIFT  = 3,
  parameter int PIPE_LAT   = 2,
  localparam int CNT_W     = $clog2(FRAME_CLKS),
  localparam int IDX_W     = CNT_W - IDX_SHIFT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_valid,
  input  logic             i_sop,
  output logic             o_twd_en,
  output logic [IDX_W-1:0] o_twd_idx,
  output logic [CNT_W-1:0] o_beat_cnt,
  output logic             o_sop,
  output logic             o_eop,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_err,
  output logic [15:0]      o_frame_cnt
);

  localparam int FL_W = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_CLKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [FL_W-1:0]     flush_q;
  logic [15:0]         frame_q;
  logic                err_q;
  logic [PIPE_LAT-1:0] vld_q;
  logic [PIPE_LAT-1:0] sop_q;
  logic [PIPE_LAT-1:0] eop_q;

  logic                in_frame_s;
  logic [CNT_W-1:0]    eff_cnt_s;
  logic                acc_s;
  logic                eop_s;
  logic                err_s;

  // Beat qualification. RUN with cnt==0 only occurs right after an EOP, where a
  // fresh SOP is required, so that case is not considered "inside a frame".
  always_comb begin
    in_frame_s = (state_q == RUN) && (cnt_q != {CNT_W{1'b0}});
    if (i_sop) begin
      eff_cnt_s = {CNT_W{1'b0}};
    end else begin
      eff_cnt_s = cnt_q;
    end
    acc_s = rstn && i_valid && (i_sop || in_frame_s);
    eop_s = acc_s && !i_sop && (cnt_q == LAST_BEAT);
    if (i_sop) begin
      err_s = i_valid && in_frame_s;
    end else begin
      err_s = i_valid && !in_frame_s;
    end
  end

  // Frame state machine, beat counter, flush timer and completed-frame counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      flush_q <= {FL_W{1'b0}};
      frame_q <= 16'd0;
    end else if (acc_s) begin
      state_q <= RUN;
      flush_q <= {FL_W{1'b0}};
      if (eop_s) begin
        cnt_q   <= {CNT_W{1'b0}};
        frame_q <= frame_q + 16'd1;
      end else begin
        cnt_q   <= eff_cnt_s + CNT_W'(1);
      end
    end else begin
      case (state_q)
        RUN: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            if (i_valid) begin
              state_q <= IDLE;
            end else begin
              state_q <= FLUSH;
              flush_q <= FL_W'(PIPE_LAT - 1);
            end
          end
        end
        FLUSH: begin
          if (flush_q == {FL_W{1'b0}}) begin
            state_q <= IDLE;
          end else begin
            flush_q <= flush_q - FL_W'(1);
          end
        end
        IDLE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= {CNT_W{1'b0}};
          flush_q <= {FL_W{1'b0}};
        end
      endcase
    end
  end

  // Delay line aligning valid/SOP/EOP with the next stage, plus the error pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= {PIPE_LAT{1'b0}};
      sop_q <= {PIPE_LAT{1'b0}};
      eop_q <= {PIPE_LAT{1'b0}};
      err_q <= 1'b0;
    end else begin
      vld_q[0] <= acc_s;
      sop_q[0] <= acc_s && i_sop;
      eop_q[0] <= eop_s;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        sop_q[i] <= sop_q[i-1];
        eop_q[i] <= eop_q[i-1];
      end
      err_q <= err_s;
    end
  end

  assign o_twd_en    = acc_s;
  assign o_twd_idx   = eff_cnt_s[CNT_W-1:IDX_SHIFT];
  assign o_beat_cnt  = acc_s ? eff_cnt_s : {CNT_W{1'b0}};
  assign o_busy      = (state_q != IDLE);
  assign o_err       = err_q;
  assign o_valid     = vld_q[PIPE_LAT-1];
  assign o_sop       = sop_q[PIPE_LAT-1];
  assign o_eop       = eop_q[PIPE_LAT-1];
  assign o_frame_cnt = frame_q;

endmodule
